// File: rtl/fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rd_data whenever rd_ok is high.
// Occupancy is held in a registered count, and both flags are decoded from that count.
module fifo #(
   parameter int ID    = 0,
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ok,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          rd_ok
);

   localparam logic [AW:0]   LP_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LP_LAST = AW'(DEPTH-1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign wr_ok   = (r_count != LP_FULL);
   assign rd_ok   = (r_count != '0);
   assign w_push  = wr_en & wr_ok & rst;
   assign w_pop   = rd_en & rd_ok & rst;
   assign rd_data = r_mem[r_rd_ptr];

   // Pointers wrap explicitly at DEPTH-1 so that non-power-of-two depths work.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst && wr_en && !wr_ok) $info("fifo %0d: write attempted while full, ignored", ID);
      if (rst && rd_en && !rd_ok) $info("fifo %0d: read attempted while empty, ignored", ID);
   end
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: a depth-4 instance and a depth-3 instance are checked
// against a queue model of expected contents and flags.
module tb_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sel = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] wr_data = '0;

   logic       a_wr_en, a_rd_en, a_wr_ok, a_rd_ok;
   logic [7:0] a_rd_data;
   logic       b_wr_en, b_rd_en, b_wr_ok, b_rd_ok;
   logic [7:0] b_rd_data;
   logic       w_wr_ok, w_rd_ok;
   logic [7:0] w_rd_data;

   logic [7:0] exp_q[$];
   int         cur_depth = 4;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   assign a_wr_en   = wr_en & ~sel;
   assign a_rd_en   = rd_en & ~sel;
   assign b_wr_en   = wr_en & sel;
   assign b_rd_en   = rd_en & sel;
   assign w_wr_ok   = sel ? b_wr_ok   : a_wr_ok;
   assign w_rd_ok   = sel ? b_rd_ok   : a_rd_ok;
   assign w_rd_data = sel ? b_rd_data : a_rd_data;

   fifo #(.ID(0), .DW(8), .AW(2), .DEPTH(4)) u_fifo4 (
      .clk(clk), .rst(rst),
      .wr_en(a_wr_en), .wr_data(wr_data), .wr_ok(a_wr_ok),
      .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_ok(a_rd_ok)
   );

   fifo #(.ID(1), .DW(8), .AW(2), .DEPTH(3)) u_fifo3 (
      .clk(clk), .rst(rst),
      .wr_en(b_wr_en), .wr_data(wr_data), .wr_ok(b_wr_ok),
      .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_ok(b_rd_ok)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a falling edge: check outputs against the model, drive one cycle, update the model.
   task automatic step(input string tag, input logic wr, input logic [7:0] d, input logic rd);
      int   sz;
      logic push_ok;
      logic pop_ok;
      sz = exp_q.size();
      chk({tag, ".rd_ok"}, 32'(w_rd_ok), 32'(sz != 0));
      chk({tag, ".wr_ok"}, 32'(w_wr_ok), 32'(sz != cur_depth));
      if (sz != 0) chk({tag, ".rd_data"}, 32'(w_rd_data), 32'(exp_q[0]));
      wr_en   = wr;
      wr_data = d;
      rd_en   = rd;
      @(posedge clk);
      push_ok = wr && (sz < cur_depth);
      pop_ok  = rd && (sz > 0);
      if (pop_ok)  void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(d);
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      // Reset state while rst is held low.
      @(negedge clk);
      chk("reset.wr_ok", 32'(a_wr_ok), 32'd1);
      chk("reset.rd_ok", 32'(a_rd_ok), 32'd0);
      chk("reset3.wr_ok", 32'(b_wr_ok), 32'd1);
      chk("reset3.rd_ok", 32'(b_rd_ok), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Single push becomes visible one cycle later.
      step("first", 1'b1, 8'hA1, 1'b0);
      step("first_vis", 1'b0, 8'h00, 1'b1);

      // Fill, overflow attempt, drain in order.
      for (int i = 1; i <= 4; i++) step("fill", 1'b1, 8'(i), 1'b0);
      step("overflow", 1'b1, 8'h05, 1'b0);
      for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1);
      step("drained", 1'b0, 8'h00, 1'b0);

      // Pop while empty is ignored.
      step("empty_pop", 1'b0, 8'h00, 1'b1);
      step("push33", 1'b1, 8'h33, 1'b0);
      step("pop33", 1'b0, 8'h00, 1'b1);
      step("empty33", 1'b0, 8'h00, 1'b0);

      // Steady-state simultaneous push/pop with two words held, wrapping the pointers.
      step("pre2", 1'b1, 8'h10, 1'b0);
      step("pre2", 1'b1, 8'h11, 1'b0);
      for (int i = 0; i < 10; i++) step("pushpop", 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      step("pp_drain", 1'b0, 8'h00, 1'b1);
      step("pp_drain", 1'b0, 8'h00, 1'b1);
      step("pp_empty", 1'b0, 8'h00, 1'b0);

      // Full: pop accepted, simultaneous push of 0x77 dropped.
      for (int i = 0; i < 4; i++) step("fill2", 1'b1, 8'(8'h40 + i), 1'b0);
      step("full_pp", 1'b1, 8'h77, 1'b1);
      for (int i = 0; i < 3; i++) step("drain3", 1'b0, 8'h00, 1'b1);
      step("after77", 1'b0, 8'h00, 1'b0);

      // Asynchronous reset mid-stream with three words held.
      for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'(8'h60 + i), 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst.rd_ok", 32'(a_rd_ok), 32'd0);
      chk("async_rst.wr_ok", 32'(a_wr_ok), 32'd1);
      exp_q.delete();
      wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("in_rst.rd_ok", 32'(a_rd_ok), 32'd0);
      chk("in_rst.wr_ok", 32'(a_wr_ok), 32'd1);
      wr_en = 1'b0; rd_en = 1'b0;
      rst = 1'b1;
      step("push5c", 1'b1, 8'h5C, 1'b0);
      step("pop5c", 1'b0, 8'h00, 1'b1);
      step("empty5c", 1'b0, 8'h00, 1'b0);

      // Depth-3 instance: push/pop pairs wrap at 3, then fill to full.
      sel = 1'b1;
      cur_depth = 3;
      for (int i = 0; i < 5; i++) begin
         step("d3_push", 1'b1, 8'(8'h80 + i), 1'b0);
         step("d3_pop", 1'b0, 8'h00, 1'b1);
      end
      for (int i = 0; i < 3; i++) step("d3_fill", 1'b1, 8'(8'h90 + i), 1'b0);
      step("d3_over", 1'b1, 8'h9F, 1'b0);
      for (int i = 0; i < 3; i++) step("d3_drain", 1'b0, 8'h00, 1'b1);
      step("d3_empty", 1'b0, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
